// File: rtl/i2c_slave_regfile.sv
// ---------------------------------------------------------------------------
// i2c_slave_regfile
//
// I2C slave with an internal register file. It supports multi-byte burst
// writes and reads, an auto-incrementing register pointer that persists across
// transactions, and repeated START. A host-side port gives on-chip logic
// direct access to the same registers. A host write beats a simultaneous bus
// write to the same register.
//
// Parameters
//   SLAVE_ADDR : 7-bit bus address
//   NREG       : number of 8-bit registers (power of 2, 2..256)
//   DEB_LEN    : glitch-filter window in clk cycles (>= 3)
//
// Ports
//   clk, rst        : system clock, synchronous active-high reset
//   scl_i, sda_i    : raw bus pin levels
//   sda_oe          : 1 = pull SDA low, 0 = release (open drain)
//   host_we         : host write strobe
//   host_addr       : host register index
//   host_wdata      : host write data
//   host_rdata      : reg[host_addr], combinational
//   i2c_wr_stb      : one-cycle pulse when a bus write updates a register
//   i2c_wr_addr     : register index written on that pulse
//   busy            : high from START to the following STOP
//
// Build option
//   I2C_SLAVE_GENCALL_EN : also ACK general-call address 7'h00 with W, and
//                          treat it as an ordinary register-file write.
// ---------------------------------------------------------------------------
module i2c_slave_regfile #(
  parameter logic [6:0]  SLAVE_ADDR = 7'h72,
  parameter int unsigned NREG       = 8,
  parameter int unsigned DEB_LEN    = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    scl_i,
  input  logic                    sda_i,
  output logic                    sda_oe,
  input  logic                    host_we,
  input  logic [$clog2(NREG)-1:0] host_addr,
  input  logic [7:0]              host_wdata,
  output logic [7:0]              host_rdata,
  output logic                    i2c_wr_stb,
  output logic [$clog2(NREG)-1:0] i2c_wr_addr,
  output logic                    busy
);

  localparam int unsigned PTR_W = $clog2(NREG);
  localparam int unsigned DCW   = $clog2(DEB_LEN);
  localparam logic [DCW-1:0] DEB_TOP = DCW'(DEB_LEN - 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_ADDR_ACK,
    S_WPTR,
    S_WDATA,
    S_RDATA,
    S_WAIT_STOP
  } state_t;

  // Bit 1 carries SCL, bit 0 carries SDA through the input path.
  logic [1:0]     pin_p0, pin_p1;
  logic [1:0]     flt_p2, flt_p3;
  logic [DCW-1:0] flt_cnt [2];

  // --- stage p0/p1: two-flop synchronizer; stage p2: glitch filter; p3: edge history
  always_ff @(posedge clk) begin
    if (rst) begin
      pin_p0 <= 2'b11;
      pin_p1 <= 2'b11;
      flt_p2 <= 2'b11;
      flt_p3 <= 2'b11;
      for (int i = 0; i < 2; i++) flt_cnt[i] <= '0;
    end else begin
      pin_p0 <= {scl_i, sda_i};
      pin_p1 <= pin_p0;
      flt_p3 <= flt_p2;
      for (int i = 0; i < 2; i++) begin
        // Flip the filtered level only after DEB_LEN-1 consecutive samples
        // disagree with it; any agreeing sample restarts the count.
        if (pin_p1[i] == flt_p2[i]) begin
          flt_cnt[i] <= '0;
        end else if (flt_cnt[i] == DEB_TOP) begin
          flt_p2[i]  <= pin_p1[i];
          flt_cnt[i] <= '0;
        end else begin
          flt_cnt[i] <= flt_cnt[i] + 1'b1;
        end
      end
    end
  end

  logic scl_f, sda_f, scl_rise, scl_fall, start_det, stop_det;
  assign scl_f     = flt_p2[1];
  assign sda_f     = flt_p2[0];
  assign scl_rise  =  flt_p2[1] & ~flt_p3[1];
  assign scl_fall  = ~flt_p2[1] &  flt_p3[1];
  // SDA edges only count as START/STOP when SCL was high on both samples.
  assign start_det = ~flt_p2[0] &  flt_p3[0] & scl_f & flt_p3[1];
  assign stop_det  =  flt_p2[0] & ~flt_p3[0] & scl_f & flt_p3[1];

  state_t           state, state_nxt;
  logic [3:0]       bit_cnt, cnt_nxt;
  logic [PTR_W-1:0] ptr, ptr_nxt;
  logic             rw, rw_nxt;
  logic             oe_nxt, busy_nxt;
  logic             shift_rx, rd_shift, load_rd, bus_we;
  logic [6:0]       rx_sr;
  logic [7:0]       rd_sr;
  logic [7:0]       rx_byte;
  logic             addr_match;
  logic [7:0]       regs [NREG];

  // Byte as it stands once the current SDA sample is shifted in.
  assign rx_byte    = {rx_sr, sda_f};
  assign host_rdata = regs[host_addr];

  always_comb begin
    addr_match = (rx_byte[7:1] == SLAVE_ADDR) && !((rx_byte[7:1] == 7'h00) && rx_byte[0]);
`ifdef I2C_SLAVE_GENCALL_EN
    if ((rx_byte[7:1] == 7'h00) && !rx_byte[0]) addr_match = 1'b1;
`else
`endif
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = bit_cnt;
    ptr_nxt   = ptr;
    rw_nxt    = rw;
    oe_nxt    = sda_oe;
    busy_nxt  = busy;
    shift_rx  = 1'b0;
    rd_shift  = 1'b0;
    load_rd   = 1'b0;
    bus_we    = 1'b0;
    if (start_det) begin
      state_nxt = S_ADDR;
      cnt_nxt   = 4'd0;
      busy_nxt  = 1'b1;
    end else if (stop_det) begin
      state_nxt = S_IDLE;
      cnt_nxt   = 4'd0;
      busy_nxt  = 1'b0;
    end else if (scl_rise) begin
      case (state)
        S_ADDR, S_WPTR, S_WDATA: begin
          if (bit_cnt != 4'd8) begin
            shift_rx = 1'b1;
            cnt_nxt  = bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
              case (state)
                S_ADDR: begin
                  if (addr_match) begin
                    state_nxt = S_ADDR_ACK;
                    rw_nxt    = rx_byte[0];
                  end else begin
                    state_nxt = S_WAIT_STOP;
                  end
                end
                S_WPTR:  ptr_nxt = rx_byte[PTR_W-1:0];
                S_WDATA: begin
                  bus_we  = 1'b1;
                  ptr_nxt = ptr + 1'b1;
                end
                default: ;
              endcase
            end
          end else begin
            // End of our ACK bit.
            cnt_nxt = 4'd0;
            if (state == S_WPTR) state_nxt = S_WDATA;
          end
        end
        S_ADDR_ACK: begin
          cnt_nxt = 4'd0;
          if (rw) begin
            state_nxt = S_RDATA;
            load_rd   = 1'b1;
          end else begin
            state_nxt = S_WPTR;
          end
        end
        S_RDATA: begin
          if (bit_cnt != 4'd8) begin
            rd_shift = 1'b1;
            cnt_nxt  = bit_cnt + 4'd1;
          end else if (!sda_f) begin
            // Master ACK: advance and prefetch the next byte.
            cnt_nxt = 4'd0;
            ptr_nxt = ptr + 1'b1;
            load_rd = 1'b1;
          end else begin
            cnt_nxt   = 4'd0;
            state_nxt = S_WAIT_STOP;
          end
        end
        default: ;
      endcase
    end else if (scl_fall) begin
      case (state)
        S_ADDR_ACK:      oe_nxt = 1'b1;
        S_WPTR, S_WDATA: oe_nxt = (bit_cnt == 4'd8);
        S_RDATA:         oe_nxt = (bit_cnt != 4'd8) ? ~rd_sr[7] : 1'b0;
        default:         oe_nxt = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      bit_cnt     <= 4'd0;
      ptr         <= '0;
      rw          <= 1'b0;
      sda_oe      <= 1'b0;
      busy        <= 1'b0;
      i2c_wr_stb  <= 1'b0;
      i2c_wr_addr <= '0;
      rx_sr       <= 7'd0;
      rd_sr       <= 8'd0;
    end else begin
      state      <= state_nxt;
      bit_cnt    <= cnt_nxt;
      ptr        <= ptr_nxt;
      rw         <= rw_nxt;
      sda_oe     <= oe_nxt;
      busy       <= busy_nxt;
      i2c_wr_stb <= bus_we;
      if (bus_we)   i2c_wr_addr <= ptr;
      if (shift_rx) rx_sr <= rx_byte[6:0];
      if (load_rd)       rd_sr <= regs[ptr_nxt];
      else if (rd_shift) rd_sr <= {rd_sr[6:0], 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= 8'd0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (host_we && (host_addr == PTR_W'(i)))  regs[i] <= host_wdata;
        else if (bus_we && (ptr == PTR_W'(i)))    regs[i] <= rx_byte;
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave_regfile.sv
`timescale 1ns/1ps
module tb_i2c_slave_regfile;

  localparam int Q = 20;  // quarter SCL period in clk cycles

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl = 1'b1;
  logic       sda_m = 1'b1;
  logic       host_we = 1'b0;
  logic [2:0] host_addr = 3'd0;
  logic [7:0] host_wdata = 8'd0;
  logic       sda_oe;
  logic [7:0] host_rdata;
  logic       i2c_wr_stb;
  logic [2:0] i2c_wr_addr;
  logic       busy;
  logic       sda_pin;

  assign sda_pin = sda_m & ~sda_oe;

  i2c_slave_regfile #(.SLAVE_ADDR(7'h72), .NREG(8), .DEB_LEN(10)) dut (
    .clk        (clk),
    .rst        (rst),
    .scl_i      (scl),
    .sda_i      (sda_pin),
    .sda_oe     (sda_oe),
    .host_we    (host_we),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .host_rdata (host_rdata),
    .i2c_wr_stb (i2c_wr_stb),
    .i2c_wr_addr(i2c_wr_addr),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [2:0] a;
    logic [7:0] d;
  } wr_exp_t;

  wr_exp_t    wr_q [$];
  logic [7:0] rd_q [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Strobe scoreboard
  int   stb_cnt = 0;
  int   oe_cnt  = 0;
  logic stb_prev = 1'b0;

  always @(negedge clk) begin
    wr_exp_t e;
    stb_prev <= i2c_wr_stb;
    if (sda_oe) oe_cnt <= oe_cnt + 1;
    if (i2c_wr_stb) begin
      stb_cnt <= stb_cnt + 1;
      chk("stb_width", stb_prev, 0);
      chk("stb_expected", wr_q.size() != 0, 1);
      if (wr_q.size() != 0) begin
        e = wr_q.pop_front();
        chk("stb_addr", i2c_wr_addr, e.a);
        if (host_addr == e.a) chk("stb_rdata", host_rdata, e.d);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bit_xfer(input logic b, input logic glitch, input logic hhit, output logic r);
    cyc(Q);
    sda_m = b;
    cyc(Q);
    scl = 1'b1;
    if (hhit) host_we = 1'b1;
    cyc(Q);
    r = sda_pin;
    if (glitch) begin
      scl = 1'b0;
      cyc(3);
      scl = 1'b1;
      cyc(Q - 3);
    end else begin
      cyc(Q);
    end
    scl = 1'b0;
    host_we = 1'b0;
  endtask

  task automatic i2c_start;
    cyc(Q);
    sda_m = 1'b1;
    cyc(Q);
    scl = 1'b1;
    cyc(2 * Q);
    sda_m = 1'b0;
    cyc(2 * Q);
    scl = 1'b0;
  endtask

  task automatic i2c_stop;
    cyc(Q);
    sda_m = 1'b0;
    cyc(Q);
    scl = 1'b1;
    cyc(2 * Q);
    sda_m = 1'b1;
    cyc(2 * Q);
  endtask

  task automatic wr_byte(input logic [7:0] d, input int glitch_bit, input logic hhit, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) bit_xfer(d[i], glitch_bit == i, hhit && (i == 0), r);
    bit_xfer(1'b1, 1'b0, 1'b0, r);
    ack = ~r;
  endtask

  task automatic rd_byte(input string tag, input logic nack);
    logic       r;
    logic [7:0] d;
    logic [7:0] e;
    d = 8'd0;
    for (int i = 0; i < 8; i++) begin
      bit_xfer(1'b1, 1'b0, 1'b0, r);
      d = {d[6:0], r};
    end
    bit_xfer(nack, 1'b0, 1'b0, r);
    e = rd_q.pop_front();
    chk(tag, d, e);
  endtask

  task automatic host_write(input logic [2:0] a, input logic [7:0] d);
    host_addr  = a;
    host_wdata = d;
    host_we    = 1'b1;
    cyc(1);
    host_we    = 1'b0;
  endtask

  task automatic host_chk(input string tag, input logic [2:0] a, input logic [7:0] d);
    host_addr = a;
    #1;
    chk(tag, host_rdata, d);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic ack;
    int   s_stb, s_oe;

    cyc(3);
    rst = 1'b0;
    cyc(2);
    chk("rst_sda_oe", sda_oe, 0);
    chk("rst_busy", busy, 0);
    chk("rst_stb", i2c_wr_stb, 0);
    chk("rst_wr_addr", i2c_wr_addr, 0);
    host_chk("rst_reg0", 3'd0, 8'h00);

    // Write burst to reg2..4
    host_addr = 3'd4;
    s_stb = stb_cnt;
    i2c_start;
    chk("wr_busy", busy, 1);
    wr_byte(8'hE4, -1, 1'b0, ack); chk("wr_ack_addr", ack, 1);
    wr_byte(8'h02, -1, 1'b0, ack); chk("wr_ack_ptr", ack, 1);
    wr_q.push_back({3'd2, 8'h11}); wr_byte(8'h11, -1, 1'b0, ack); chk("wr_ack_d0", ack, 1);
    wr_q.push_back({3'd3, 8'h22}); wr_byte(8'h22, -1, 1'b0, ack); chk("wr_ack_d1", ack, 1);
    wr_q.push_back({3'd4, 8'h33}); wr_byte(8'h33, -1, 1'b0, ack); chk("wr_ack_d2", ack, 1);
    i2c_stop;
    chk("wr_busy_after_stop", busy, 0);
    chk("wr_stb_count", stb_cnt - s_stb, 3);
    host_chk("wr_reg2", 3'd2, 8'h11);
    host_chk("wr_reg3", 3'd3, 8'h22);
    host_chk("wr_reg4", 3'd4, 8'h33);

    // Repeated-START read with pointer wrap
    host_write(3'd6, 8'hA6);
    host_write(3'd7, 8'h57);
    host_write(3'd0, 8'h0F);
    i2c_start;
    wr_byte(8'hE4, -1, 1'b0, ack); chk("rd_ack_waddr", ack, 1);
    wr_byte(8'h06, -1, 1'b0, ack); chk("rd_ack_ptr", ack, 1);
    i2c_start;
    wr_byte(8'hE5, -1, 1'b0, ack); chk("rd_ack_raddr", ack, 1);
    rd_q.push_back(8'hA6); rd_q.push_back(8'h57); rd_q.push_back(8'h0F);
    rd_byte("rd_byte0", 1'b0);
    rd_byte("rd_byte1", 1'b0);
    rd_byte("rd_byte2", 1'b1);
    cyc(Q);
    chk("rd_release", sda_oe, 0);
    i2c_stop;

    // Address mismatch
    s_stb = stb_cnt;
    s_oe  = oe_cnt;
    i2c_start;
    wr_byte(8'hA0, -1, 1'b0, ack); chk("mm_ack_addr", ack, 0);
    wr_byte(8'h12, -1, 1'b0, ack); chk("mm_ack_d0", ack, 0);
    wr_byte(8'h34, -1, 1'b0, ack); chk("mm_ack_d1", ack, 0);
    chk("mm_busy", busy, 1);
    i2c_stop;
    chk("mm_busy_after_stop", busy, 0);
    chk("mm_oe_cycles", oe_cnt - s_oe, 0);
    chk("mm_stb", stb_cnt - s_stb, 0);

    // General call with W
    i2c_start;
    wr_byte(8'h00, -1, 1'b0, ack);
`ifdef I2C_SLAVE_GENCALL_EN
    chk("gc_ack", ack, 1);
`else
    chk("gc_ack", ack, 0);
`endif
    i2c_stop;

    // Glitch rejection on SCL during data bits
    i2c_start;
    wr_byte(8'hE4, -1, 1'b0, ack); chk("gl_ack_addr", ack, 1);
    wr_byte(8'h05, 2, 1'b0, ack);  chk("gl_ack_ptr", ack, 1);
    wr_q.push_back({3'd5, 8'hC3});
    wr_byte(8'hC3, 4, 1'b0, ack);  chk("gl_ack_d", ack, 1);
    i2c_stop;
    host_chk("gl_reg5", 3'd5, 8'hC3);

    // Host/bus collision on reg3
    i2c_start;
    wr_byte(8'hE4, -1, 1'b0, ack); chk("co_ack_addr", ack, 1);
    wr_byte(8'h03, -1, 1'b0, ack); chk("co_ack_ptr", ack, 1);
    host_addr  = 3'd3;
    host_wdata = 8'h5A;
    s_stb = stb_cnt;
    wr_q.push_back({3'd3, 8'h5A});
    wr_byte(8'hA5, -1, 1'b1, ack); chk("co_ack_d", ack, 1);
    i2c_stop;
    chk("co_stb", stb_cnt - s_stb, 1);
    host_chk("co_reg3", 3'd3, 8'h5A);

    // Reset in the middle of a read
    i2c_start;
    wr_byte(8'hE4, -1, 1'b0, ack); chk("rr_ack_waddr", ack, 1);
    wr_byte(8'h01, -1, 1'b0, ack); chk("rr_ack_ptr", ack, 1);
    i2c_stop;
    host_write(3'd1, 8'h3C);
    i2c_start;
    wr_byte(8'hE5, -1, 1'b0, ack); chk("rr_ack_raddr", ack, 1);
    for (int i = 0; i < 60 && !sda_oe; i++) cyc(1);
    chk("rr_oe_before", sda_oe, 1);
    rst = 1'b1;
    cyc(1);
    chk("rr_oe_after", sda_oe, 0);
    chk("rr_busy_after", busy, 0);
    scl   = 1'b1;
    sda_m = 1'b1;
    cyc(3);
    rst = 1'b0;
    cyc(30);
    for (int i = 0; i < 8; i++) host_chk("rr_reg_clear", 3'(i), 8'h00);
    i2c_start;
    wr_byte(8'hE5, -1, 1'b0, ack); chk("rr_ack_read", ack, 1);
    rd_q.push_back(8'h00);
    rd_byte("rr_read0", 1'b1);
    i2c_stop;

    cyc(10);
    chk("wr_q_empty", wr_q.size(), 0);
    chk("rd_q_empty", rd_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
